// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter encodings, FSM state type and counter update helper
// Package for the BHT update controller: 2-bit counter values, controller
// states and the saturating counter update used on every write-back.
package bp_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } bp_state_e;

  // Move a 2-bit counter one step toward the outcome, holding at the rails.
  function automatic logic [1:0] bp_sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == BP_ST) ? BP_ST : cnt + 2'b01;
    end else begin
      nxt = (cnt == BP_SNT) ? BP_SNT : cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - resolve queue of {index, taken} entries
// Synchronous FIFO with clear. A push while full is accepted only when a pop
// frees a slot in the same cycle; clear discards contents and any same-cycle push.
module bp_upd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next pointers, storage and occupancy; clear has priority over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Queue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - BHT update sequencer: queued read-modify-write of 2-bit counters
// Resolved branches are queued and applied as READ/WRITE pairs on the table's
// update port. Define BP_INIT_EN to walk-initialize the table after reset and flush.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int LINES    = 128,
  parameter int QDEPTH   = 4,
  localparam int IDXW    = $clog2(LINES),
  localparam int CW      = $clog2(QDEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                resolve_valid,
  input  logic [PC_WIDTH-1:0] resolve_pc,
  input  logic                resolve_taken,
  input  logic                flush_req,
  output logic [IDXW-1:0]     tbl_addr,
  output logic                tbl_rd_en,
  input  logic [1:0]          tbl_rdata,
  output logic                tbl_we,
  output logic [1:0]          tbl_wdata,
  output logic                busy,
  output logic [CW-1:0]       q_count,
  output logic [15:0]         drop_cnt
);

  localparam int EW = IDXW + 1;

`ifdef BP_INIT_EN
  localparam bp_state_e RESET_STATE = ST_INIT;
`else
  localparam bp_state_e RESET_STATE = ST_IDLE;
`endif

  bp_state_e       state_q, state_d;
  logic [IDXW-1:0] cur_idx_q, cur_idx_d;
  logic            cur_taken_q, cur_taken_d;
  logic [15:0]     drop_q, drop_d;

  logic [IDXW-1:0] res_idx;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_head;
  logic            push;
  logic            pop;
  logic            drop_evt;
  logic            unused_pc_bits;

  // Word-aligned PCs: bits [1:0] and the bits above the index never reach the table.
  assign res_idx        = resolve_pc[IDXW+1:2];
  assign unused_pc_bits = ^{resolve_pc[PC_WIDTH-1:IDXW+2], resolve_pc[1:0]};

  bp_upd_fifo #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (flush_req),
    .push      (push),
    .push_data ({res_idx, resolve_taken}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (q_count)
  );

  // Pop the head when starting a new RMW; a flush suppresses it.
  always_comb begin
    pop = 1'b0;
    if (!flush_req && !fifo_empty && (state_q == ST_IDLE || state_q == ST_WRITE)) begin
      pop = 1'b1;
    end
  end

  // Accept a resolve when a slot is free (or freed this cycle), else count a drop.
  always_comb begin
    push     = 1'b0;
    drop_evt = 1'b0;
    if (resolve_valid && !flush_req) begin
      if (!fifo_full || pop) begin
        push = 1'b1;
      end else begin
        drop_evt = 1'b1;
      end
    end
  end

  // Saturating drop counter; survives flush, cleared only by reset.
  always_comb begin
    drop_d = drop_q;
    if (drop_evt && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

`ifdef BP_INIT_EN
  logic [IDXW-1:0] walk_q, walk_d;

  // Init walk pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      walk_q <= '0;
    end else begin
      walk_q <= walk_d;
    end
  end
`endif

  // Next-state logic; the popped head is latched so READ and WRITE share it.
  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    cur_taken_d = cur_taken_q;
`ifdef BP_INIT_EN
    walk_d      = walk_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef BP_INIT_EN
        walk_d = walk_q + IDXW'(1);
        if (walk_q == IDXW'(LINES - 1)) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = pop ? ST_READ : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (pop) begin
      {cur_idx_d, cur_taken_d} = fifo_head;
    end
    if (flush_req) begin
`ifdef BP_INIT_EN
      state_d = ST_INIT;
      walk_d  = '0;
`else
      state_d = ST_IDLE;
`endif
    end
  end

  // Table port strobes decoded from the registered state only.
  always_comb begin
    tbl_addr  = '0;
    tbl_rd_en = 1'b0;
    tbl_we    = 1'b0;
    tbl_wdata = 2'b00;
    case (state_q)
      ST_INIT: begin
`ifdef BP_INIT_EN
        tbl_we    = 1'b1;
        tbl_wdata = BP_WNT;
        tbl_addr  = walk_q;
`endif
      end
      ST_READ: begin
        tbl_rd_en = 1'b1;
        tbl_addr  = cur_idx_q;
      end
      ST_WRITE: begin
        tbl_we    = 1'b1;
        tbl_addr  = cur_idx_q;
        tbl_wdata = bp_sat_update(tbl_rdata, cur_taken_q);
      end
      default: begin
        tbl_addr = '0;
      end
    endcase
  end

  // Controller state, current entry and drop counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      cur_idx_q   <= '0;
      cur_taken_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      cur_taken_q <= cur_taken_d;
      drop_q      <= drop_d;
    end
  end

`ifdef BP_INIT_EN
  assign busy = (state_q == ST_INIT);
`else
  assign busy = 1'b0;
`endif

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb/tb_bp_update_ctrl.sv - directed self-checking bench for bp_update_ctrl
module tb_bp_update_ctrl;

  localparam int LINES = 128;

`ifdef BP_INIT_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = '0;
  logic        resolve_taken = 1'b0;
  logic        flush_req = 1'b0;
  logic [6:0]  tbl_addr;
  logic        tbl_rd_en;
  logic [1:0]  tbl_rdata;
  logic        tbl_we;
  logic [1:0]  tbl_wdata;
  logic        busy;
  logic [2:0]  q_count;
  logic [15:0] drop_cnt;

  logic        mem_clr = 1'b1;
  logic [1:0]  mem [LINES];
  logic [6:0]  wr_addr_log [$];
  logic [1:0]  wr_data_log [$];

  int errors = 0;
  int checks = 0;

  bp_update_ctrl #(
    .PC_WIDTH (32),
    .LINES    (LINES),
    .QDEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .resolve_valid (resolve_valid),
    .resolve_pc    (resolve_pc),
    .resolve_taken (resolve_taken),
    .flush_req     (flush_req),
    .tbl_addr      (tbl_addr),
    .tbl_rd_en     (tbl_rd_en),
    .tbl_rdata     (tbl_rdata),
    .tbl_we        (tbl_we),
    .tbl_wdata     (tbl_wdata),
    .busy          (busy),
    .q_count       (q_count),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  // Table storage model with a synchronous read port.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < LINES; i++) mem[i] <= 2'b01;
      tbl_rdata <= 2'b00;
    end else begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      if (tbl_rd_en) tbl_rdata <= mem[tbl_addr];
    end
  end

  // Write log of every committed table write.
  always @(posedge clk) begin
    if (reset && tbl_we) begin
      wr_addr_log.push_back(tbl_addr);
      wr_data_log.push_back(tbl_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk);
    @(negedge clk);
    resolve_valid = 1'b1;
    resolve_pc    = pc;
    resolve_taken = tk;
    @(posedge clk);
    #1;
    resolve_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q_count == 3'd0 && !tbl_rd_en && !tbl_we && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic clear_log();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  initial begin
    logic [1:0] sat_exp [8];
    logic       ok;
    int         n;
    sat_exp = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, EXP_BUSY_RST);
    check("rst_rd_en", tbl_rd_en, 0);
    check("rst_q_count", q_count, 0);
    check("rst_drop_cnt", drop_cnt, 0);
`ifndef BP_INIT_EN
    check("rst_we", tbl_we, 0);
    check("rst_addr", tbl_addr, 0);
    check("rst_wdata", tbl_wdata, 0);
`endif
    mem_clr = 1'b0;
    clear_log();
    reset = 1'b1;

`ifdef BP_INIT_EN
    // Init walk: 128 busy cycles, 01 written to lines 0..127 in order
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("init_busy_cycles", n, 128);
    check("init_write_count", wr_addr_log.size(), 128);
    ok = 1'b1;
    for (int i = 0; i < wr_addr_log.size() && i < 128; i++) begin
      if (wr_addr_log[i] != 7'(i) || wr_data_log[i] != 2'b01) ok = 1'b0;
    end
    check("init_order", {31'd0, ok}, 1);
`else
    @(negedge clk);
    check("idle_busy", busy, 0);
`endif

    // Single resolve pc=0x104 taken -> line 0x41, 01 -> 10
    clear_log();
    resolve(32'h0000_0104, 1'b1);
    @(negedge clk);
    check("single_q_count", q_count, 1);
    check("single_idle_rd", tbl_rd_en, 0);
    @(negedge clk);
    check("single_read_en", tbl_rd_en, 1);
    check("single_read_addr", tbl_addr, 7'h41);
    check("single_read_q", q_count, 0);
    @(negedge clk);
    check("single_write_en", tbl_we, 1);
    check("single_write_addr", tbl_addr, 7'h41);
    check("single_write_data", tbl_wdata, 2'b10);
    wait_quiet("single_drain");
    check("single_mem", mem[7'h41], 2'b10);

    // Saturation on line 5: 01 -> 10, then 3 taken, then 4 not taken
    clear_log();
    for (int i = 0; i < 4; i++) resolve(32'h14, 1'b1);
    wait_quiet("sat_up_drain");
    for (int i = 0; i < 4; i++) resolve(32'h14, 1'b0);
    wait_quiet("sat_dn_drain");
    check("sat_write_count", wr_data_log.size(), 8);
    for (int i = 0; i < wr_data_log.size() && i < 8; i++) begin
      check("sat_wdata", wr_data_log[i], sat_exp[i]);
      check("sat_addr", wr_addr_log[i], 7'd5);
    end

    // Overflow: 12 back-to-back resolves on lines 16..27, entries 24 and 26 dropped
    clear_log();
    for (int i = 0; i < 12; i++) resolve((32'd16 + 32'(i)) << 2, 1'b1);
    check("ovf_drop_cnt", drop_cnt, 2);
    wait_quiet("ovf_drain");
    check("ovf_write_count", wr_addr_log.size(), 10);
    check("ovf_mem16", mem[16], 2'b10);
    check("ovf_mem24", mem[24], 2'b01);
    check("ovf_mem25", mem[25], 2'b10);
    check("ovf_mem26", mem[26], 2'b01);
    check("ovf_mem27", mem[27], 2'b10);

    // Flush during READ of line 42 with 3 queued and a same-cycle resolve
    clear_log();
    for (int i = 0; i < 6; i++) resolve((32'd40 + 32'(i)) << 2, 1'b1);
    @(negedge clk);
    check("flush_pre_rd", tbl_rd_en, 1);
    check("flush_pre_addr", tbl_addr, 7'd42);
    check("flush_pre_q", q_count, 3);
    flush_req     = 1'b1;
    resolve_valid = 1'b1;
    resolve_pc    = 32'd46 << 2;
    resolve_taken = 1'b1;
    @(posedge clk);
    #1;
    flush_req     = 1'b0;
    resolve_valid = 1'b0;
    @(negedge clk);
    check("flush_q_count", q_count, 0);
    check("flush_rd_en", tbl_rd_en, 0);
    check("flush_drop_cnt", drop_cnt, 2);
    check("flush_mem41", mem[41], 2'b10);
    check("flush_mem42", mem[42], 2'b01);
`ifdef BP_INIT_EN
    check("flush_busy", busy, 1);
    check("flush_init_addr", tbl_addr, 0);
    check("flush_init_wdata", tbl_wdata, 2'b01);
`else
    check("flush_we", tbl_we, 0);
    check("flush_busy", busy, 0);
`endif
    wait_quiet("flush_drain");
`ifndef BP_INIT_EN
    check("flush_write_count", wr_addr_log.size(), 2);
    check("flush_mem46", mem[46], 2'b01);
`endif

    // Async reset in the middle of the WRITE of line 50, line 51 queued
    clear_log();
    resolve(32'd50 << 2, 1'b1);
    resolve(32'd51 << 2, 1'b1);
    @(negedge clk);
    check("arst_read_addr", tbl_addr, 7'd50);
    @(negedge clk);
    check("arst_pre_we", tbl_we, 1);
    check("arst_pre_q", q_count, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_q_count", q_count, 0);
    check("arst_rd_en", tbl_rd_en, 0);
    check("arst_drop_cnt", drop_cnt, 0);
    check("arst_busy", busy, EXP_BUSY_RST);
`ifndef BP_INIT_EN
    check("arst_we", tbl_we, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    check("arst_mem50", mem[50], 2'b01);
    wait_quiet("arst_drain");
    check("arst_mem51", mem[51], 2'b01);
`ifndef BP_INIT_EN
    check("arst_write_count", wr_addr_log.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
